// File: rtl/bht_update_ctrl.sv
// Branch history table update controller.
// Owns the global history register (speculative shift plus mispredict
// recovery), queues ALU branch resolutions in a small FIFO, and drains
// them into the 2-bit counter table through a single read-modify-write
// port. Direct counter writes from software take priority over the queue.
// Optional feature: define BHT_INIT_SWEEP_EN to sweep every counter to
// weakly-taken (2'b10) after reset before normal operation starts.
module bht_update_ctrl #(
    parameter int GHR_SIZE      = 8,
    parameter int ADDRESS_WIDTH = 22,
    parameter int QUEUE_DEPTH   = 4
) (
    input  logic                             i_Clk,
    input  logic                             i_Reset_n,
    input  logic                             i_Stall,
    input  logic                             i_pred_valid,
    input  logic [ADDRESS_WIDTH-1:0]         i_pred_pc,
    input  logic                             i_pred_taken,
    input  logic                             i_res_valid,
    input  logic [GHR_SIZE-1:0]              i_res_index,
    input  logic                             i_res_taken,
    input  logic                             i_res_mispredict,
    input  logic [GHR_SIZE-1:0]              i_res_ghr,
    input  logic                             i_cfg_wr_valid,
    input  logic [GHR_SIZE-1:0]              i_cfg_wr_index,
    input  logic [1:0]                       i_cfg_wr_data,
    output logic [GHR_SIZE-1:0]              o_rd_index,
    input  logic [1:0]                       i_rd_data,
    output logic                             o_wr_en,
    output logic [GHR_SIZE-1:0]              o_wr_index,
    output logic [1:0]                       o_wr_data,
    output logic [GHR_SIZE-1:0]              o_ghr,
    output logic [GHR_SIZE-1:0]              o_pred_index,
    output logic                             o_busy,
    output logic                             o_stall_req,
    output logic                             o_overflow,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0] o_q_count
);

    localparam int PTR_W   = $clog2(QUEUE_DEPTH);
    localparam int CNT_W   = $clog2(QUEUE_DEPTH+1);
    localparam int ENTRY_W = GHR_SIZE + 1;

    // Saturating 2-bit counter step toward the resolved direction.
    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        if (taken) begin
            return (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
        end else begin
            return (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
        end
    endfunction

    logic run;
    logic busy;

`ifdef BHT_INIT_SWEEP_EN
    typedef enum logic {ST_INIT, ST_RUN} state_t;

    localparam logic [GHR_SIZE-1:0] SWEEP_LAST = '1;

    state_t              state, state_nxt;
    logic [GHR_SIZE-1:0] sweep_ptr, sweep_ptr_nxt;

    // Sweep state and pointer registers; reset restarts the sweep at 0.
    always_ff @(posedge i_Clk) begin
        if (!i_Reset_n) begin
            state     <= ST_INIT;
            sweep_ptr <= '0;
        end else begin
            state     <= state_nxt;
            sweep_ptr <= sweep_ptr_nxt;
        end
    end

    // Walk every table entry once, then enter RUN for good.
    always_comb begin
        state_nxt     = state;
        sweep_ptr_nxt = sweep_ptr;
        if (state == ST_INIT) begin
            sweep_ptr_nxt = sweep_ptr + 1'b1;
            if (sweep_ptr == SWEEP_LAST) begin
                state_nxt = ST_RUN;
            end
        end
    end

    assign run  = (state == ST_RUN);
    assign busy = (state == ST_INIT);
`else
    assign run  = 1'b1;
    assign busy = 1'b0;
`endif

    // Resolution FIFO: {index, taken} entries.
    logic [ENTRY_W-1:0]  mem [QUEUE_DEPTH];
    logic [PTR_W-1:0]    rd_ptr, wr_ptr;
    logic [CNT_W-1:0]    count;
    logic                overflow;
    logic [ENTRY_W-1:0]  head;
    logic [GHR_SIZE-1:0] head_index;
    logic                head_taken;
    logic                empty, full;
    logic                push_req, push, pop, drop;
    logic [GHR_SIZE-1:0] ghr;

    assign head       = mem[rd_ptr];
    assign head_index = head[ENTRY_W-1:1];
    assign head_taken = head[0];
    assign empty      = (count == '0);
    assign full       = (count == CNT_W'(QUEUE_DEPTH));

    // A full queue still accepts a push when the head leaves the same cycle.
    assign push_req = run & i_res_valid;
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    // Counter-table write arbitration: sweep, then software write, then queue head.
    always_comb begin
        o_wr_en    = 1'b0;
        o_wr_index = '0;
        o_wr_data  = 2'b00;
        pop        = 1'b0;
`ifdef BHT_INIT_SWEEP_EN
        if (busy) begin
            o_wr_en    = 1'b1;
            o_wr_index = sweep_ptr;
            o_wr_data  = 2'b10;
        end else
`endif
        if (i_cfg_wr_valid) begin
            o_wr_en    = 1'b1;
            o_wr_index = i_cfg_wr_index;
            o_wr_data  = i_cfg_wr_data;
        end else if (!empty) begin
            o_wr_en    = 1'b1;
            o_wr_index = head_index;
            o_wr_data  = sat_update(i_rd_data, head_taken);
            pop        = 1'b1;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge i_Clk) begin
        if (!i_Reset_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (drop) overflow <= 1'b1;
        end
    end

    // FIFO storage holds data only, so it carries no reset.
    always_ff @(posedge i_Clk) begin
        if (push) begin
            mem[wr_ptr] <= {i_res_index, i_res_taken};
        end
    end

    // GHR: mispredict recovery from the checkpoint beats the speculative shift.
    always_ff @(posedge i_Clk) begin
        if (!i_Reset_n) begin
            ghr <= '0;
        end else if (run) begin
            if (i_res_valid && i_res_mispredict) begin
                ghr <= {i_res_ghr[GHR_SIZE-2:0], i_res_taken};
            end else if (i_pred_valid && !i_Stall) begin
                ghr <= {ghr[GHR_SIZE-2:0], i_pred_taken};
            end
        end
    end

    // Upper PC bits and the oldest checkpoint bit do not feed any logic.
    logic unused_bits;
    assign unused_bits = ^{i_pred_pc[ADDRESS_WIDTH-1:GHR_SIZE], i_res_ghr[GHR_SIZE-1]};

    assign o_rd_index   = head_index;
    assign o_ghr        = ghr;
    assign o_pred_index = ghr ^ i_pred_pc[GHR_SIZE-1:0];
    assign o_busy       = busy;
    assign o_stall_req  = busy | (count >= CNT_W'(QUEUE_DEPTH-1));
    assign o_overflow   = overflow;
    assign o_q_count    = count;

endmodule

// File: tb/tb_bht_update_ctrl.sv
// Self-checking bench for bht_update_ctrl with default parameters.
module tb_bht_update_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        pred_valid;
    logic [21:0] pred_pc;
    logic        pred_taken;
    logic        res_valid;
    logic [7:0]  res_index;
    logic        res_taken;
    logic        res_misp;
    logic [7:0]  res_ghr;
    logic        cfg_valid;
    logic [7:0]  cfg_index;
    logic [1:0]  cfg_data;
    logic [7:0]  rd_index;
    logic [1:0]  rd_data;
    logic        wr_en;
    logic [7:0]  wr_index;
    logic [1:0]  wr_data;
    logic [7:0]  ghr;
    logic [7:0]  pred_index;
    logic        busy;
    logic        stall_req;
    logic        overflow;
    logic [2:0]  q_count;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    bht_update_ctrl dut (
        .i_Clk            (clk),
        .i_Reset_n        (rst_n),
        .i_Stall          (stall),
        .i_pred_valid     (pred_valid),
        .i_pred_pc        (pred_pc),
        .i_pred_taken     (pred_taken),
        .i_res_valid      (res_valid),
        .i_res_index      (res_index),
        .i_res_taken      (res_taken),
        .i_res_mispredict (res_misp),
        .i_res_ghr        (res_ghr),
        .i_cfg_wr_valid   (cfg_valid),
        .i_cfg_wr_index   (cfg_index),
        .i_cfg_wr_data    (cfg_data),
        .o_rd_index       (rd_index),
        .i_rd_data        (rd_data),
        .o_wr_en          (wr_en),
        .o_wr_index       (wr_index),
        .o_wr_data        (wr_data),
        .o_ghr            (ghr),
        .o_pred_index     (pred_index),
        .o_busy           (busy),
        .o_stall_req      (stall_req),
        .o_overflow       (overflow),
        .o_q_count        (q_count)
    );

    typedef struct {
        logic [7:0] index;
        logic       taken;
        logic [1:0] rd;
        logic [1:0] exp_wr;
    } rmw_vec_t;

    rmw_vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] ghr_bits;
        logic [7:0] drain_idx [4];
        logic       drain_tkn [4];
        logic [1:0] drain_exp [4];
        int         n;

        vecs[0] = '{8'h00, 1'b0, 2'd0, 2'd0};
        vecs[1] = '{8'h01, 1'b1, 2'd0, 2'd1};
        vecs[2] = '{8'h7F, 1'b0, 2'd1, 2'd0};
        vecs[3] = '{8'h80, 1'b1, 2'd1, 2'd2};
        vecs[4] = '{8'hFF, 1'b0, 2'd2, 2'd1};
        vecs[5] = '{8'h5A, 1'b1, 2'd2, 2'd3};
        vecs[6] = '{8'hA5, 1'b0, 2'd3, 2'd2};
        vecs[7] = '{8'h3C, 1'b1, 2'd3, 2'd3};

        rst_n = 1'b0; stall = 1'b0; pred_valid = 1'b0; pred_pc = '0; pred_taken = 1'b0;
        res_valid = 1'b0; res_index = '0; res_taken = 1'b0; res_misp = 1'b0; res_ghr = '0;
        cfg_valid = 1'b0; cfg_index = '0; cfg_data = '0; rd_data = '0;

        // Reset state
        step(); step();
        chk("reset_ghr", 32'(ghr), 32'h0);
        chk("reset_qcount", 32'(q_count), 32'h0);
        chk("reset_overflow", 32'(overflow), 32'h0);
        rst_n = 1'b1;

`ifdef BHT_INIT_SWEEP_EN
        n = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (!busy) break;
            chk("sweep_write", {21'h0, wr_en, wr_index, wr_data}, {21'h0, 1'b1, n[7:0], 2'b10});
            n++;
        end
        chk("sweep_len", 32'(n), 32'd256);
`else
        n = 0;
        @(negedge clk);
        chk("first_wr_en", 32'(wr_en), 32'h0);
        chk("busy_low", 32'(busy), 32'h0);
`endif
        chk("stall_req_idle", 32'(stall_req), 32'h0);
        step();

        // Table-driven read-modify-write saturation vectors
        for (int i = 0; i < 8; i++) begin
            res_valid = 1'b1; res_index = vecs[i].index; res_taken = vecs[i].taken; res_misp = 1'b0;
            step();
            res_valid = 1'b0;
            rd_data   = vecs[i].rd;
            @(negedge clk);
            chk("rmw_rd_index", 32'(rd_index), 32'(vecs[i].index));
            chk("rmw_wr", {29'h0, wr_en, wr_data}, {29'h0, 1'b1, vecs[i].exp_wr});
            chk("rmw_wr_index", 32'(wr_index), 32'(vecs[i].index));
            step();
            chk("rmw_drained", 32'(q_count), 32'h0);
        end

        // Build GHR = A5 through speculative shifts
        ghr_bits = 8'hA5;
        for (int b = 7; b >= 0; b--) begin
            pred_valid = 1'b1; pred_taken = ghr_bits[b];
            step();
        end
        pred_valid = 1'b0;
        chk("ghr_a5", 32'(ghr), 32'hA5);
        pred_pc = 22'h3ABC3C;
        @(negedge clk);
        chk("pred_index", 32'(pred_index), 32'h99);
        step();

        // Mispredict recovery overrides a same-cycle speculative shift
        pred_valid = 1'b1; pred_taken = 1'b1;
        res_valid = 1'b1; res_misp = 1'b1; res_ghr = 8'h0F; res_taken = 1'b0; res_index = 8'h03;
        step();
        pred_valid = 1'b0; res_valid = 1'b0; res_misp = 1'b0;
        chk("ghr_recover", 32'(ghr), 32'h1E);
        chk("recover_pushed", 32'(q_count), 32'h1);
        rd_data = 2'd1;
        @(negedge clk);
        chk("recover_drain", {22'h0, wr_index, wr_data}, {22'h0, 8'h03, 2'd0});
        step();

        // Stall freezes the GHR but not the resolution queue
        stall = 1'b1; pred_valid = 1'b1; pred_taken = 1'b1;
        res_valid = 1'b1; res_index = 8'h44; res_taken = 1'b1;
        step();
        res_valid = 1'b0;
        chk("stall_ghr", 32'(ghr), 32'h1E);
        chk("stall_pushed", 32'(q_count), 32'h1);
        rd_data = 2'd2;
        @(negedge clk);
        chk("stall_drain", {21'h0, wr_en, wr_index, wr_data}, {21'h0, 1'b1, 8'h44, 2'd3});
        step();
        chk("stall_ghr_hold", 32'(ghr), 32'h1E);
        chk("stall_drained", 32'(q_count), 32'h0);
        stall = 1'b0; pred_valid = 1'b0;

        // Software write wins over a pending queue entry
        res_valid = 1'b1; res_index = 8'h10; res_taken = 1'b1;
        step();
        res_valid = 1'b0;
        cfg_valid = 1'b1; cfg_index = 8'h20; cfg_data = 2'd1;
        @(negedge clk);
        chk("cfg_priority", {21'h0, wr_en, wr_index, wr_data}, {21'h0, 1'b1, 8'h20, 2'd1});
        step();
        chk("cfg_no_pop", 32'(q_count), 32'h1);
        cfg_valid = 1'b0; rd_data = 2'd0;
        @(negedge clk);
        chk("cfg_then_fifo", {21'h0, wr_en, wr_index, wr_data}, {21'h0, 1'b1, 8'h10, 2'd1});
        step();
        chk("cfg_drained", 32'(q_count), 32'h0);

        // Fill past depth with pops blocked by software writes
        cfg_valid = 1'b1; cfg_index = 8'h00; cfg_data = 2'd2;
        for (int k = 0; k < 5; k++) begin
            res_valid = 1'b1; res_index = 8'h51 + 8'(k); res_taken = k[0];
            if (k == 4) chk("overflow_before", 32'(overflow), 32'h0);
            step();
            chk("fill_qcount", 32'(q_count), (k < 4) ? 32'(k + 1) : 32'd4);
            chk("fill_stall_req", 32'(stall_req), (k >= 2) ? 32'd1 : 32'd0);
            chk("fill_overflow", 32'(overflow), (k == 4) ? 32'd1 : 32'd0);
        end
        res_valid = 1'b0; cfg_valid = 1'b0;

        // Push and pop together at full occupancy
        res_valid = 1'b1; res_index = 8'h56; res_taken = 1'b1; rd_data = 2'd1;
        @(negedge clk);
        chk("full_pp_head", {22'h0, rd_index, wr_data}, {22'h0, 8'h51, 2'd0});
        step();
        res_valid = 1'b0;
        chk("full_pp_count", 32'(q_count), 32'h4);

        drain_idx[0] = 8'h52; drain_tkn[0] = 1'b1; drain_exp[0] = 2'd2;
        drain_idx[1] = 8'h53; drain_tkn[1] = 1'b0; drain_exp[1] = 2'd0;
        drain_idx[2] = 8'h54; drain_tkn[2] = 1'b1; drain_exp[2] = 2'd2;
        drain_idx[3] = 8'h56; drain_tkn[3] = 1'b1; drain_exp[3] = 2'd2;
        for (int d = 0; d < 4; d++) begin
            rd_data = 2'd1;
            @(negedge clk);
            chk("drain_order", {21'h0, wr_en, wr_index, wr_data}, {21'h0, 1'b1, drain_idx[d], drain_exp[d]});
            step();
        end
        chk("drain_empty", 32'(q_count), 32'h0);
        chk("overflow_sticky", 32'(overflow), 32'h1);
        chk("stall_req_clear", 32'(stall_req), 32'h0);

        // Reset clears queue, overflow and GHR
        res_valid = 1'b1; res_index = 8'h77; res_taken = 1'b0;
        step();
        res_valid = 1'b0; cfg_valid = 1'b1;
        rst_n = 1'b0;
        step();
        cfg_valid = 1'b0;
        chk("rst2_qcount", 32'(q_count), 32'h0);
        chk("rst2_overflow", 32'(overflow), 32'h0);
        chk("rst2_ghr", 32'(ghr), 32'h0);
        rst_n = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bht_update_ctrl.md
BHT_UPDATE_CTRL -- requirements
Module: bht_update_ctrl

Interface
REQ-001 SHALL have parameter GHR_SIZE, default 8, meaning history length and table index width (2^GHR_SIZE entries).
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 22, meaning fetch PC width.
REQ-003 SHALL have parameter QUEUE_DEPTH, default 4, meaning resolution-update FIFO depth (power of two, >=2).
REQ-004 SHALL have port i_Clk, in, 1, system clock; all state on rising edge.
REQ-005 SHALL have port i_Reset_n, in, 1, reset, synchronous, active-low.
REQ-006 SHALL have port i_Stall, in, 1, pipeline stall; freezes speculative GHR shift only.
REQ-007 SHALL have ports i_pred_valid (in, 1), i_pred_pc (in, ADDRESS_WIDTH) and i_pred_taken (in, 1), carrying a fetch-stage branch prediction.
REQ-008 SHALL have ports i_res_valid (in, 1), i_res_index (in, GHR_SIZE), i_res_taken (in, 1), i_res_mispredict (in, 1) and i_res_ghr (in, GHR_SIZE), carrying an ALU branch resolution with its prediction-time index and GHR checkpoint.
REQ-009 SHALL have ports i_cfg_wr_valid (in, 1), i_cfg_wr_index (in, GHR_SIZE) and i_cfg_wr_data (in, 2), carrying a debug/software direct counter write.
REQ-010 SHALL have ports o_rd_index (out, GHR_SIZE) and i_rd_data (in, 2), forming the asynchronous counter-table read port.
REQ-011 SHALL have ports o_wr_en (out, 1), o_wr_index (out, GHR_SIZE) and o_wr_data (out, 2), forming the synchronous counter-table write port.
REQ-012 SHALL have ports o_ghr (out, GHR_SIZE) and o_pred_index (out, GHR_SIZE), giving the current GHR and GHR XOR i_pred_pc[GHR_SIZE-1:0] (combinational).
REQ-013 SHALL have ports o_busy (out, 1), o_stall_req (out, 1), o_overflow (out, 1, sticky) and o_q_count (out, clog2(QUEUE_DEPTH+1)).

Function
REQ-014 SHALL implement states INIT and RUN; INIT->RUN after the last sweep write; RUN exits only via reset.
REQ-015 In INIT SHALL drive o_wr_en=1, o_wr_index=sweep pointer, o_wr_data=2'b10, incrementing the pointer each cycle from 0 to 2^GHR_SIZE-1 (2^GHR_SIZE cycles total); o_busy=1.
REQ-016 In INIT SHALL ignore i_pred_valid, i_res_valid and i_cfg_wr_valid; GHR and FIFO held.
REQ-017 In RUN, i_res_valid SHALL push {i_res_index, i_res_taken} into the FIFO regardless of i_Stall.
REQ-018 Write-port arbitration in RUN SHALL be: i_cfg_wr_valid first (write i_cfg_wr_data to i_cfg_wr_index, no FIFO pop), else FIFO head if non-empty (pop), else o_wr_en=0.
REQ-019 FIFO-head write SHALL be read-modify-write in one cycle: o_rd_index=head index; o_wr_data=i_rd_data+1 saturating at 3 if taken, i_rd_data-1 saturating at 0 if not taken.
REQ-020 Push and pop in the same cycle SHALL be legal at any occupancy, including full; count unchanged.
REQ-021 A push when full without a same-cycle pop SHALL be dropped and set o_overflow until reset.
REQ-022 o_stall_req SHALL equal o_busy OR (o_q_count >= QUEUE_DEPTH-1).
REQ-023 In RUN, i_res_valid AND i_res_mispredict SHALL load GHR <= {i_res_ghr[GHR_SIZE-2:0], i_res_taken}, overriding any same-cycle speculative shift.
REQ-024 Otherwise, i_pred_valid AND NOT i_Stall in RUN SHALL shift GHR <= {GHR[GHR_SIZE-2:0], i_pred_taken}.
REQ-025 Consecutive updates to the same index SHALL each observe the previous write (no forwarding needed; write lands before next read).

Reset
REQ-026 On i_Reset_n=0 at a clock edge SHALL set GHR=0, FIFO empty, o_q_count=0, o_overflow=0, sweep pointer=0, state=INIT.
REQ-027 Reset asserted mid-sweep SHALL restart the sweep from index 0.
REQ-028 o_wr_en SHALL be 1 (INIT sweep) in the first cycle after reset release when the sweep is compiled in, else 0.

Configuration
REQ-029 Macro BHT_INIT_SWEEP_EN defined SHALL include the INIT sweep as specified.
REQ-030 Macro BHT_INIT_SWEEP_EN undefined SHALL reset directly into RUN, o_busy constantly 0, no sweep logic synthesised.

Verification
REQ-031 Reset release, GHR_SIZE=8 -> 256 writes of 2'b10 to indices 0..255, o_busy high exactly 256 cycles, then RUN.
REQ-032 i_rd_data=3, res taken -> o_wr_data=3; i_rd_data=0, res not-taken -> o_wr_data=0; i_rd_data=1, taken -> 2.
REQ-033 cfg write and non-empty FIFO same cycle -> cfg index/data written, o_q_count unchanged; FIFO write next cycle.
REQ-034 Five res pushes with cfg writes blocking pops, depth 4 -> o_stall_req at count 3, fifth dropped, o_overflow=1.
REQ-035 GHR=8'hA5, pred_valid taken plus mispredict with i_res_ghr=8'h0F, res_taken=0 same cycle -> GHR=8'h1E.
REQ-036 i_Stall=1 with pred_valid -> GHR unchanged; res update still pushed and drained.
